game_of_life_ctrl: RTL

Sequencer for the 8x8 toroidal game_of_life next-state datapath. Owns the board register. Accepts a seed pattern, then advances generations at a programmed rate or one at a time on request, and counts generations. Halts automatically on extinction, a still life, or a generation limit. Sits between the top-level button/LED logic and the datapath: drives its update and current_bits, and consumes its registered next_bits.

---
 rtl/game_of_life_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/game_of_life_ctrl.sv
// Generation sequencer for the 8x8 toroidal life datapath: owns the board, paces
// free-run/step generations, counts them and halts on extinction, still life or limit.
module game_of_life_ctrl #(
  parameter int unsigned TICKS_PER_GEN = 12_000_000,
  parameter int unsigned GEN_W         = 16,
  parameter int unsigned MAX_GENS      = 32'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_valid,
  input  logic [63:0]      seed_bits,
  output logic             seed_ready,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  output logic             gol_update,
  output logic [63:0]      gol_current,
  input  logic [63:0]      gol_next,
  output logic [63:0]      board,
  output logic [GEN_W-1:0] gen_count,
  output logic             running,
  output logic             halted,
  output logic [1:0]       halt_reason
);

  localparam int TW = (TICKS_PER_GEN > 1) ? $clog2(TICKS_PER_GEN) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICKS_PER_GEN - 1);
  localparam logic [GEN_W-1:0] GEN_LIMIT = GEN_W'(MAX_GENS);

  localparam logic [1:0] HALT_NONE    = 2'd0;
  localparam logic [1:0] HALT_STABLE  = 2'd1;
  localparam logic [1:0] HALT_EXTINCT = 2'd2;
  localparam logic [1:0] HALT_LIMIT   = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    UPDATE  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [63:0]      board_nxt;
  logic [GEN_W-1:0] gen_nxt;
  logic [GEN_W-1:0] gen_inc;
  logic [1:0]       reason_nxt;
  logic [TW-1:0]    tick, tick_nxt;
  logic             free_run, free_nxt;
  logic             seed_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      board       <= '0;
      gen_count   <= '0;
      halt_reason <= HALT_NONE;
      tick        <= '0;
      free_run    <= 1'b0;
    end else begin
      state       <= state_nxt;
      board       <= board_nxt;
      gen_count   <= gen_nxt;
      halt_reason <= reason_nxt;
      tick        <= tick_nxt;
      free_run    <= free_nxt;
    end
  end

  assign seed_ready  = (state == IDLE) || (state == DONE);
  assign seed_hs     = seed_valid && seed_ready;
  assign gen_inc     = gen_count + 1'b1;
  assign gol_update  = (state == UPDATE);
  assign gol_current = board;
  assign halted      = (state == DONE);
  assign running     = free_run && ((state == RUN) || (state == UPDATE) || (state == CAPTURE));

  always_comb begin
    state_nxt  = state;
    board_nxt  = board;
    gen_nxt    = gen_count;
    reason_nxt = halt_reason;
    tick_nxt   = tick;
    free_nxt   = free_run;

    case (state)
      IDLE: begin
        if (seed_hs) begin
          board_nxt  = seed_bits;
          gen_nxt    = '0;
          reason_nxt = HALT_NONE;
          tick_nxt   = '0;
          free_nxt   = 1'b0;
        end else if (stop) begin
          free_nxt = 1'b0;
        end else if (start) begin
          state_nxt = RUN;
          tick_nxt  = '0;
          free_nxt  = 1'b1;
        end else if (step) begin
          state_nxt = UPDATE;
          free_nxt  = 1'b0;
        end
      end

      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
          free_nxt  = 1'b0;
        end else if (tick == TICK_LAST) begin
          state_nxt = UPDATE;
          tick_nxt  = '0;
        end else begin
          tick_nxt = tick + 1'b1;
        end
      end

      UPDATE: begin
        state_nxt = CAPTURE;
        if (stop) free_nxt = 1'b0;
      end

      CAPTURE: begin
        board_nxt = gol_next;
        gen_nxt   = gen_inc;
        // A stop seen in this very cycle still cancels the return to RUN.
        if (stop) free_nxt = 1'b0;
        if (gol_next == '0) begin
          state_nxt  = DONE;
          reason_nxt = HALT_EXTINCT;
        end else if (gol_next == board) begin
          state_nxt  = DONE;
          reason_nxt = HALT_STABLE;
        end else if (gen_inc == GEN_LIMIT) begin
          state_nxt  = DONE;
          reason_nxt = HALT_LIMIT;
        end else if (free_run && !stop) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end

      DONE: begin
        if (seed_hs) begin
          state_nxt  = IDLE;
          board_nxt  = seed_bits;
          gen_nxt    = '0;
          reason_nxt = HALT_NONE;
          tick_nxt   = '0;
          free_nxt   = 1'b0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
